// File: rtl/watchdog_trip.sv
// watchdog_trip: trip handler downstream of a watchdog timer core (expiry vs host stop, reset pulse, cause, trip count).
//
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   wd_ready         - timer core ready (0 while running)
//   wd_curr          - timer core current count
//   wd_start_stop    - start/stop pulse also seen by the core
//   warn_threshold   - early-warning level, 0 disables
//   rst_len          - reset pulse length in cycles (0 acts as 1), sampled at trip entry
//   clear_cause      - pulse, clears expired
//   sys_reset_req    - system reset request, high for max(rst_len,1) cycles after an expiry
//   warn_irq         - early-warning level interrupt
//   expired          - sticky: last run ended by expiry
//   trip_count       - saturating expiry count
//
// Define WATCHDOG_TRIP_WARN_EN to build the early-warning comparator; otherwise warn_irq is tied 0.
module watchdog_trip #(
  parameter int RST_LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wd_ready,
  input  logic [31:0]          wd_curr,
  input  logic                 wd_start_stop,
  input  logic [31:0]          warn_threshold,
  input  logic [RST_LEN_W-1:0] rst_len,
  input  logic                 clear_cause,
  output logic                 sys_reset_req,
  output logic                 warn_irq,
  output logic                 expired,
  output logic [7:0]           trip_count
);
  typedef enum logic [1:0] {IDLE, ARMED, TRIP} state_e;
  state_e state_q, state_d;
  logic [RST_LEN_W-1:0] cnt_q, cnt_d;
  logic stop_seen_q, stop_seen_d;
  logic ready_prev_q;
  logic expired_q, expired_d;
  logic [7:0] trip_count_q, trip_count_d;
  logic warn_q, warn_d;
  logic rise;
  logic [RST_LEN_W-1:0] len1;
  assign rise = !ready_prev_q && wd_ready;
  assign len1 = (rst_len == '0) ? RST_LEN_W'(1) : rst_len;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stop_seen_d = stop_seen_q;
    // a trip entry below overrides the clear, so the set wins
    expired_d = expired_q && !clear_cause;
    trip_count_d = trip_count_q;
    case (state_q)
      IDLE: begin
        stop_seen_d = 1'b0;
        state_d = wd_ready ? IDLE : ARMED;
      end
      ARMED: begin
        stop_seen_d = stop_seen_q || wd_start_stop;
        if (rise) begin
          // a stop seen earlier or on this very cycle means the core was stopped, not expired
          if (stop_seen_q || wd_start_stop) state_d = IDLE;
          else begin
            state_d = TRIP;
            cnt_d = len1;
            expired_d = 1'b1;
            trip_count_d = (trip_count_q == 8'hff) ? trip_count_q : trip_count_q + 8'd1;
          end
        end
      end
      TRIP: begin
        cnt_d = cnt_q - RST_LEN_W'(1);
        state_d = (cnt_q <= RST_LEN_W'(1)) ? IDLE : TRIP;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef WATCHDOG_TRIP_WARN_EN
  // warning latches while the run stays armed and clears on any exit from ARMED
  assign warn_d = (state_q == ARMED && state_d == ARMED) &&
                  (warn_q || (warn_threshold != 32'd0 && wd_curr <= warn_threshold));
`else
  logic unused_warn;
  assign unused_warn = ^{warn_threshold, wd_curr};
  assign warn_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stop_seen_q <= 1'b0;
      ready_prev_q <= 1'b1;
      expired_q <= 1'b0;
      trip_count_q <= 8'd0;
      warn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stop_seen_q <= stop_seen_d;
      ready_prev_q <= wd_ready;
      expired_q <= expired_d;
      trip_count_q <= trip_count_d;
      warn_q <= warn_d;
    end
  end
  assign sys_reset_req = (state_q == TRIP);
  assign warn_irq = warn_q;
  assign expired = expired_q;
  assign trip_count = trip_count_q;
endmodule
